// File: rtl/mul_seq.sv
// mul_seq: multi-cycle shift-add multiplier sequencer for the EX-stage MUL.
// Holds the pipeline via stall_o while iterating and pulses valid_o with the
// low WIDTH bits of the product.
// Optional feature macro: MUL_EARLY_EXIT_EN (finish RUN as soon as the
// remaining multiplier bits are all zero).
module mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             valid_q;

  logic [WIDTH-1:0] acc_d;
  logic             last_iter;
  logic             mplier_zero;

  // Partial-product accumulation for the current multiplier bit
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  // Final iteration of a full-length run
  always_comb begin
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

`ifdef MUL_EARLY_EXIT_EN
  // Remaining multiplier bits exhausted: acc already holds the product
  always_comb begin
    mplier_zero = (mplier_q == '0);
  end
`else
  // Early exit disabled: comparator not built
  always_comb begin
    mplier_zero = 1'b0;
  end
`endif

  // Sequencer FSM with datapath registers and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            mcand_q  <= src1_i;
            mplier_q <= src2_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else if (mplier_zero) begin
            result_q <= acc_q;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            // result is loaded with the post-add value so it is ready in DONE
            if (last_iter) begin
              result_q <= acc_d;
              valid_q  <= 1'b1;
              state_q  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Pipeline hold: only start_i/flush_i reach stall_o combinationally
  always_comb begin
    stall_o = ((state_q == S_RUN) && !flush_i) ||
              ((state_q == S_IDLE) && start_i && !flush_i);
  end

  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed-vector bench for mul_seq (WIDTH=32), both with and
// without MUL_EARLY_EXIT_EN.
module tb_mul_seq;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;
  time t_acc;

  mul_seq #(.WIDTH(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .src1_i   (src1),
    .src2_i   (src2),
    .flush_i  (flush),
    .stall_o  (stall_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a negedge with the DUT in IDLE. Counts RUN cycles via
  // stall_o and checks the product when valid_o appears.
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_run,
                        input bit toggle, input bit keep);
    int run;
    bit seen;
    src1 = a; src2 = b; start = 1'b1;
    #1;
    check({tag, "_stall_start"}, {31'd0, stall_o}, 32'd1);
    @(posedge clk);
    t_acc = $time;
    run  = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid_o) begin
        seen = 1'b1;
        break;
      end
      if (stall_o) run++;
      if (toggle) begin
        start = ~start;
        src1  = $urandom;
        src2  = $urandom;
      end
    end
    check({tag, "_valid_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_run_cycles"}, run, exp_run);
    check({tag, "_result"}, result_o, exp);
    check({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
    if (keep) begin
      start = 1'b1;
    end else begin
      start = 1'b0;
      @(negedge clk);
      check({tag, "_valid_pulse"}, {31'd0, valid_o}, 32'd0);
      check({tag, "_stall_idle"}, {31'd0, stall_o}, 32'd0);
      check({tag, "_result_hold"}, result_o, exp);
    end
  endtask

  initial begin
    time t_first;
    rst = 1'b1; start = 1'b0; flush = 1'b0; src1 = '0; src2 = '0;
    repeat (2) @(negedge clk);
    check("reset_result", result_o, 32'd0);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_mul("m6x7", 32'd6, 32'd7, 32'd42, EE ? 4 : 32, 1'b0, 1'b0);
    do_mul("neg1x2", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, EE ? 3 : 32, 1'b0, 1'b0);
    do_mul("trunc", 32'h8000_0000, 32'd2, 32'h0000_0000, EE ? 3 : 32, 1'b0, 1'b0);
    do_mul("m5x3", 32'd5, 32'd3, 32'd15, EE ? 3 : 32, 1'b0, 1'b0);
    do_mul("m9x0", 32'd9, 32'd0, 32'd0, EE ? 1 : 32, 1'b0, 1'b0);
    do_mul("m1xmsb", 32'd1, 32'h8000_0000, 32'h8000_0000, 32, 1'b0, 1'b0);
    do_mul("m3x5", 32'd3, 32'd5, 32'd15, EE ? 4 : 32, 1'b0, 1'b0);

    // flush has priority over start in IDLE
    start = 1'b1; flush = 1'b1; src1 = 32'd11; src2 = 32'd13;
    #1;
    check("idle_flush_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("idle_flush_not_accepted", {31'd0, stall_o}, 32'd0);
    @(negedge clk);

    // flush in the 10th RUN cycle
    src1 = 32'd5; src2 = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    check("flush_run_stall_before", {31'd0, stall_o}, 32'd1);
    flush = 1'b1;
    #1;
    check("flush_stall_drop", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush_idle_stall", {31'd0, stall_o}, 32'd0);
    check("flush_no_valid", {31'd0, valid_o}, 32'd0);
    check("flush_result_kept", result_o, 32'd15);
    repeat (40) begin
      @(negedge clk);
      if (valid_o) check("flush_late_valid", {31'd0, valid_o}, 32'd0);
    end
    do_mul("m2x3", 32'd2, 32'd3, 32'd6, EE ? 3 : 32, 1'b0, 1'b0);

    // asynchronous reset mid-RUN
    src1 = 32'hFFFF; src2 = 32'hFFFF; start = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_result", result_o, 32'd0);
    check("arst_valid", {31'd0, valid_o}, 32'd0);
    check("arst_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_mul("m4x4", 32'd4, 32'd4, 32'd16, EE ? 4 : 32, 1'b0, 1'b0);

    // start/operand changes during RUN are ignored
    do_mul("toggle3x5", 32'd3, 32'd5, 32'd15, EE ? 4 : 32, 1'b1, 1'b0);

    // back-to-back: second MUL accepted in the IDLE cycle after DONE
    do_mul("b2b_7x8", 32'd7, 32'd8, 32'd56, EE ? 5 : 32, 1'b0, 1'b1);
    t_first = t_acc;
    src1 = 32'd9; src2 = 32'd9;
    @(negedge clk);
    do_mul("b2b_9x9", 32'd9, 32'd9, 32'd81, EE ? 5 : 32, 1'b0, 1'b0);
    check("b2b_spacing", 32'((t_acc - t_first) / 10), EE ? 32'd7 : 32'd34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle sequencer for the ALU's multiply operation (ALUCtrl code 4'hA). It is placed beside the EX-stage ALU. When ID/EX presents a MUL, it runs an iterative shift-add multiply and holds the pipeline with a stall until the product is ready. It returns the low WIDTH bits of the product to the EX result mux, and the hazard unit ORs its stall into the pipeline-hold signal.

## Interface
- WIDTH, 32: operand and result width; must be at least 2.
- clk_i  input  1  clock, all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  the EX-stage instruction is MUL (ALUCtrl == 4'hA); held high while the pipeline is stalled.
- src1_i  input  WIDTH  multiplicand (rs value after forwarding).
- src2_i  input  WIDTH  multiplier (rt value after forwarding).
- flush_i  input  1  the EX-stage instruction is squashed; aborts any operation in progress.
- stall_o  output  1  hold PC, IF/ID and ID/EX; keep EX/MEM from capturing.
- valid_o  output  1  result_o is the product of the accepted operands; high for exactly one cycle.
- result_o  output  WIDTH  low WIDTH bits of src1×src2; identical for signed and unsigned operands.

## Operation
- States: IDLE, RUN, DONE. Internal registers:
  - mcand (WIDTH bits, shifts left)
  - mplier (WIDTH bits, shifts right)
  - acc (WIDTH bits)
  - cnt ($clog2(WIDTH)+1 bits)
- IDLE, start_i=1, flush_i=0 at an edge:
  - mcand←src1_i, mplier←src2_i, acc←0, cnt←0; go to RUN.
- IDLE, otherwise: stay in IDLE.
- RUN, per edge:
  - if mplier[0]=1, acc←acc+mcand (mod 2^WIDTH);
  - mcand←mcand<<1, mplier←mplier>>1, cnt←cnt+1;
  - when cnt==WIDTH-1 at that edge, go to DONE.
- DONE: result_o←acc on entry; valid_o=1 for this one cycle; next edge returns to IDLE.
- start_i is ignored in RUN and DONE. A new MUL is accepted only from IDLE.
- stall_o is combinational: high in RUN, and high in IDLE when start_i=1 and flush_i=0. It is low in DONE, which lets the pipeline advance on the DONE edge while EX captures result_o.
- flush_i=1 in RUN or DONE: go to IDLE at the next edge. valid_o is not asserted for the aborted operation, result_o keeps its previous value, and stall_o drops combinationally in the flush cycle.
- flush_i has priority over start_i in IDLE.
- Reset, any time including mid-RUN: state=IDLE, acc, mcand, mplier, cnt and result_o = 0, valid_o=0, stall_o=0.

## Timing
- Accept edge E0 (start_i sampled in IDLE). RUN covers the cycles after E0 through E_WIDTH. DONE is the cycle after E_WIDTH.
- Start-to-valid latency: WIDTH+1 cycles, giving WIDTH+1 stall cycles including the start cycle.
- result_o is registered and stable from DONE until the next DONE or reset.
- Back-to-back MULs: the second MUL reaches EX in the cycle after DONE (IDLE) and is accepted at that cycle's edge. Minimum spacing between accepts is WIDTH+2 cycles.
- No combinational path from src1_i/src2_i to any output. The only combinational path is start_i/flush_i → stall_o.

## Configuration
- MUL_EARLY_EXIT_EN defined:
  - in RUN, if mplier==0 at an edge, go to DONE without adding or shifting;
  - RUN length is msb_index(src2)+2 cycles, or 1 cycle if src2==0, capped at WIDTH;
  - acc is unchanged by the exit, so result_o is identical to the full run.
- MUL_EARLY_EXIT_EN undefined:
  - always exactly WIDTH RUN cycles, fixed latency WIDTH+1;
  - the mplier==0 comparator is not built.

## Test plan
- Reset, then 6×7 with WIDTH=32, no macro:
  - stall_o high from the start cycle for 33 cycles;
  - valid_o pulses once, 33 cycles after the accept cycle, with result_o=42.
- 0xFFFFFFFF×0x00000002 → result_o=0xFFFFFFFE (signed −1×2). Also 0x80000000×2 → 0x00000000 (truncation).
- With MUL_EARLY_EXIT_EN:
  - 5×3 gives 3 RUN cycles and result_o=15;
  - 9×0 gives 1 RUN cycle and result_o=0;
  - 1×0x80000000 gives 32 RUN cycles and result_o=0x80000000.
- flush_i pulsed in the 10th RUN cycle:
  - state is IDLE next cycle, stall_o low, no valid_o;
  - result_o unchanged;
  - a following 2×3 yields 6.
- rst_i asserted asynchronously mid-RUN: all outputs 0 immediately. After release, 4×4 yields 16.
- start_i toggled during RUN with different operands: ignored, and the result matches the originally accepted operands. Then two MULs back-to-back (7×8, then 9×9) give 56 then 81, with accepts spaced WIDTH+2 cycles apart.
